// File: rtl/div_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share one handshake-based
// FP32 divider; a single division is in flight at any time.
module div_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 32
) (
  input  logic                     aclk,
  input  logic                     rstn,
  input  logic [N_REQ*DW-1:0]      req_a,
  input  logic [N_REQ*DW-1:0]      req_b,
  input  logic [N_REQ-1:0]         req_stb,
  output logic [N_REQ-1:0]         req_ack,
  output logic [DW-1:0]            resp_z,
  output logic [N_REQ-1:0]         resp_stb,
  input  logic [N_REQ-1:0]         resp_ack,
  output logic [DW-1:0]            div_input_a,
  output logic                     div_input_a_stb,
  input  logic                     div_input_a_ack,
  output logic [DW-1:0]            div_input_b,
  output logic                     div_input_b_stb,
  input  logic                     div_input_b_ack,
  input  logic [DW-1:0]            div_output_z,
  input  logic                     div_output_z_stb,
  output logic                     div_output_z_ack,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic [15:0]              done_count
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RETURN
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     win_id;
  logic              win_vld;
  logic [N_REQ-1:0]  win_oh;
  logic [DW-1:0]     win_a;
  logic [DW-1:0]     win_b;
  logic [DW-1:0]     a_q;
  logic [DW-1:0]     b_q;
  logic [DW-1:0]     z_q;
  logic              grant;
  logic              result_in;
  logic              result_out;

  // Search upward from the slot after the last served requester, wrapping.
  always_comb begin : arb_search
    logic [IW:0] cand;
    cand    = '0;
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N_REQ)) begin
        cand = cand - (IW+1)'(N_REQ);
      end
      if (!win_vld && req_stb[cand[IW-1:0]]) begin
        win_vld = 1'b1;
        win_id  = cand[IW-1:0];
      end
    end
  end

  always_comb begin : win_select
    win_oh = '0;
    win_a  = '0;
    win_b  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win_id == IW'(k)) begin
        win_oh[k] = 1'b1;
        win_a     = req_a[k*DW +: DW];
        win_b     = req_b[k*DW +: DW];
      end
    end
  end

  assign grant      = (state == S_IDLE) && win_vld;
  assign result_in  = (state == S_WAIT) && div_output_z_stb;
  assign result_out = (state == S_RETURN) && resp_ack[grant_id];

  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin : fsm_next
    state_nxt        = state;
    div_input_a_stb  = 1'b0;
    div_input_b_stb  = 1'b0;
    div_output_z_ack = 1'b0;
    resp_stb         = '0;
    busy             = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (win_vld) begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        div_input_a_stb = 1'b1;
        div_input_b_stb = 1'b1;
        // Both channels must accept together; a lone ack is not a transfer.
        if (div_input_a_ack && div_input_b_ack) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        div_output_z_ack = 1'b1;
        if (div_output_z_stb) begin
          state_nxt = S_RETURN;
        end
      end
      S_RETURN: begin
        resp_stb[grant_id] = 1'b1;
        if (resp_ack[grant_id]) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      ptr        <= IW'(N_REQ - 1);
      grant_id   <= '0;
      req_ack    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      z_q        <= '0;
      done_count <= '0;
    end else begin
      req_ack <= grant ? win_oh : '0;
      if (grant) begin
        grant_id <= win_id;
        a_q      <= win_a;
        b_q      <= win_b;
      end
      if (result_in) begin
        z_q <= div_output_z;
      end
      if (result_out) begin
        ptr        <= grant_id;
        done_count <= done_count + 16'd1;
      end
    end
  end

  assign div_input_a = a_q;
  assign div_input_b = b_q;
  assign resp_z      = z_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: requester agents, a behavioural divider with
// configurable latency/partial acks, and a per-port result scoreboard.
module tb_div_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;

  logic            aclk = 1'b0;
  logic            rstn = 1'b0;
  logic [N*DW-1:0] req_a = '0;
  logic [N*DW-1:0] req_b = '0;
  logic [N-1:0]    req_stb = '0;
  logic [N-1:0]    req_ack;
  logic [DW-1:0]   resp_z;
  logic [N-1:0]    resp_stb;
  logic [N-1:0]    resp_ack = '0;
  logic [DW-1:0]   div_input_a;
  logic            div_input_a_stb;
  logic            div_input_a_ack = 1'b0;
  logic [DW-1:0]   div_input_b;
  logic            div_input_b_stb;
  logic            div_input_b_ack = 1'b0;
  logic [DW-1:0]   div_output_z = '0;
  logic            div_output_z_stb = 1'b0;
  logic            div_output_z_ack;
  logic            busy;
  logic [1:0]      grant_id;
  logic [15:0]     done_count;

  div_arbiter #(.N_REQ(N), .DW(DW)) dut (
    .aclk(aclk), .rstn(rstn),
    .req_a(req_a), .req_b(req_b), .req_stb(req_stb), .req_ack(req_ack),
    .resp_z(resp_z), .resp_stb(resp_stb), .resp_ack(resp_ack),
    .div_input_a(div_input_a), .div_input_a_stb(div_input_a_stb), .div_input_a_ack(div_input_a_ack),
    .div_input_b(div_input_b), .div_input_b_stb(div_input_b_stb), .div_input_b_ack(div_input_b_ack),
    .div_output_z(div_output_z), .div_output_z_stb(div_output_z_stb), .div_output_z_ack(div_output_z_ack),
    .busy(busy), .grant_id(grant_id), .done_count(done_count)
  );

  always #5 aclk = ~aclk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
  endtask

  // The divider stand-in: known FP32 cases plus a scrambling function.
  function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (a == 32'h3F80_0000 && b == 32'h0000_0000) return 32'h7F80_0000;
    return {a[15:0], a[31:16]} ^ (b * 32'd3 + 32'h1234_5678);
  endfunction

  logic [31:0] pa_q[N][$];
  logic [31:0] pb_q[N][$];
  logic [31:0] exp_q[N][$];
  int          grant_log[$];

  int force_stall = -1;
  int max_stall   = 0;
  int stall[N];
  bit in_resp[N];
  int raise_cyc[N];
  int wait_cyc[N];
  int svc[N];

  // Requester agents: raise pending work, drop stb on ack, answer results.
  always @(negedge aclk) begin
    if (!rstn) begin
      req_stb  = '0;
      resp_ack = '0;
      for (int i = 0; i < N; i++) begin
        pa_q[i].delete();
        pb_q[i].delete();
        exp_q[i].delete();
        in_resp[i] = 1'b0;
      end
    end else begin
      check("ack_onehot", 32'($countones(req_ack) <= 1), 32'd1);
      check("resp_onehot", 32'($countones(resp_stb) <= 1), 32'd1);
      for (int i = 0; i < N; i++) begin
        if (req_ack[i]) begin
          grant_log.push_back(i);
          wait_cyc[i] = cyc - raise_cyc[i];
          check("ack_had_stb", 32'(req_stb[i]), 32'd1);
          check("starvation", 32'(svc[i] <= 3), 32'd1);
          for (int j = 0; j < N; j++) if (j != i && req_stb[j]) svc[j]++;
          req_stb[i] = 1'b0;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!req_stb[i] && !req_ack[i] && pa_q[i].size() > 0) begin
          req_a[i*DW +: DW] = pa_q[i].pop_front();
          req_b[i*DW +: DW] = pb_q[i].pop_front();
          req_stb[i]   = 1'b1;
          raise_cyc[i] = cyc;
          svc[i]       = 0;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (resp_ack[i]) begin
          resp_ack[i] = 1'b0;
        end else if (resp_stb[i]) begin
          if (!in_resp[i]) begin
            in_resp[i] = 1'b1;
            stall[i] = (force_stall >= 0) ? force_stall : int'($urandom_range(max_stall, 0));
          end
          if (stall[i] > 0) begin
            stall[i]--;
          end else begin
            if (exp_q[i].size() == 0) check("resp_unexpected", 32'(i), 32'hFFFF_FFFF);
            else check("resp_z", resp_z, exp_q[i].pop_front());
            resp_ack[i] = 1'b1;
            in_resp[i]  = 1'b0;
          end
        end
      end
    end
  end

  int lat_min = 1;
  int lat_max = 1;
  bit partial = 1'b0;
  int dst     = 0;
  int dcnt    = 0;
  logic [31:0] cap_a;
  logic [31:0] cap_b;
  bit z_xfer   = 1'b0;
  bit chk_drop = 1'b0;
  bit chk_hold = 1'b0;

  // Divider model: accepts operands, returns fdiv() after a set latency.
  always @(negedge aclk) begin
    if (!rstn) begin
      dst = 0;
      div_input_a_ack  = 1'b0;
      div_input_b_ack  = 1'b0;
      div_output_z_stb = 1'b0;
      z_xfer   = 1'b0;
      chk_drop = 1'b0;
      chk_hold = 1'b0;
    end else begin
      if (chk_drop) check("div_stb_drop", 32'({div_input_a_stb, div_input_b_stb}), 32'd0);
      if (chk_hold) check("div_stb_hold", 32'({div_input_a_stb, div_input_b_stb}), 32'd3);
      chk_drop = 1'b0;
      chk_hold = 1'b0;
      div_input_a_ack = 1'b0;
      div_input_b_ack = 1'b0;
      case (dst)
        0: if (div_input_a_stb && div_input_b_stb) begin
          div_input_a_ack = partial ? 1'($urandom_range(1, 0)) : 1'b1;
          div_input_b_ack = partial ? 1'($urandom_range(1, 0)) : 1'b1;
          if (div_input_a_ack && div_input_b_ack) begin
            cap_a = div_input_a;
            cap_b = div_input_b;
            dcnt  = int'($urandom_range(lat_max, lat_min));
            dst   = 1;
            chk_drop = 1'b1;
          end else if (div_input_a_ack || div_input_b_ack) begin
            chk_hold = 1'b1;
          end
        end
        1: begin
          dcnt--;
          if (dcnt <= 0) begin
            div_output_z     = fdiv(cap_a, cap_b);
            div_output_z_stb = 1'b1;
            if (div_output_z_ack) z_xfer = 1'b1;
            dst = 2;
          end
        end
        default: begin
          if (z_xfer) begin
            div_output_z_stb = 1'b0;
            z_xfer = 1'b0;
            dst = 0;
          end else if (div_output_z_ack) begin
            z_xfer = 1'b1;
          end
        end
      endcase
    end
  end

  task automatic push(input int p, input logic [31:0] a, input logic [31:0] b);
    pa_q[p].push_back(a);
    pb_q[p].push_back(b);
    exp_q[p].push_back(fdiv(a, b));
  endtask

  function automatic int outstanding();
    int s = 0;
    for (int i = 0; i < N; i++) s += exp_q[i].size();
    return s;
  endfunction

  task automatic drain(input int budget, input string tag);
    int k = 0;
    while (k < budget && (outstanding() != 0 || busy)) begin
      @(negedge aclk);
      k++;
    end
    @(negedge aclk);
    check(tag, 32'(outstanding()), 32'd0);
  endtask

  task automatic reset_pulse();
    @(negedge aclk);
    rstn = 1'b0;
    repeat (2) @(negedge aclk);
    #1 rstn = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int base;
    int k;
    int p;
    repeat (3) @(negedge aclk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_done_count", 32'(done_count), 32'd0);
    check("rst_acks", 32'({req_ack, resp_stb}), 32'd0);
    check("rst_div_ctl", 32'({div_input_a_stb, div_input_b_stb, div_output_z_ack}), 32'd0);
    check("rst_div_ops", div_input_a | div_input_b, 32'd0);
    check("rst_resp_z", resp_z, 32'd0);

    // 6.0 / 2.0 on port 0, first request straight after reset
    @(negedge aclk);
    #1 rstn = 1'b1;
    push(0, 32'h40C0_0000, 32'h4000_0000);
    drain(200, "t_single_drain");
    check("t_single_done", 32'(done_count), 32'd1);
    check("t_single_grant", 32'(grant_id), 32'd0);
    check("t_single_grant_lat", 32'(wait_cyc[0]), 32'd1);

    // All four requesters at once after reset
    reset_pulse();
    grant_log.delete();
    for (int i = 0; i < N; i++) push(i, 32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i * 7));
    drain(400, "t_all4_drain");
    check("t_all4_acks", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < grant_log.size() && i < 4; i++) check("t_all4_order", 32'(grant_log[i]), 32'(i));
    check("t_all4_done", 32'(done_count), 32'd4);

    // 1.0 / 0.0 on port 2; port 1 raised while it is in flight
    lat_min = 8; lat_max = 8;
    grant_log.delete();
    push(2, 32'h3F80_0000, 32'h0000_0000);
    k = 0;
    while (!busy && k < 50) begin @(negedge aclk); k++; end
    check("t_inf_busy", 32'(busy), 32'd1);
    repeat (2) @(negedge aclk);
    push(1, 32'hC2F6_0000, 32'h4120_0000);
    drain(400, "t_inf_drain");
    check("t_inf_n", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      check("t_inf_first", 32'(grant_log[0]), 32'd2);
      check("t_inf_next", 32'(grant_log[1]), 32'd1);
    end
    check("t_inf_done", 32'(done_count), 32'd6);

    // Long resp_ack stall on port 0 with another request pending
    lat_min = 1; lat_max = 1;
    force_stall = 12;
    push(0, 32'h40C0_0000, 32'h4000_0000);
    k = 0;
    while (!resp_stb[0] && k < 100) begin @(negedge aclk); k++; end
    check("t_stall_resp", 32'(resp_stb), 32'd1);
    push(1, 32'h0BAD_F00D, 32'h1234_0000);
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      check("t_stall_stb", 32'(resp_stb), 32'd1);
      check("t_stall_z", resp_z, 32'h4040_0000);
      check("t_stall_noack", 32'(req_ack), 32'd0);
      check("t_stall_divstb", 32'({div_input_a_stb, div_input_b_stb}), 32'd0);
    end
    force_stall = -1;
    drain(400, "t_stall_drain");
    check("t_stall_done", 32'(done_count), 32'd8);

    // Reset while the divider is working
    lat_min = 20; lat_max = 20;
    push(3, 32'h4248_0000, 32'h40A0_0000);
    k = 0;
    while (!div_output_z_ack && k < 100) begin @(negedge aclk); k++; end
    check("t_rst_in_wait", 32'(div_output_z_ack), 32'd1);
    @(negedge aclk);
    #2 rstn = 1'b0;
    #1;
    check("t_rst_busy", 32'(busy), 32'd0);
    check("t_rst_ctl", 32'({req_ack, resp_stb, div_input_a_stb, div_input_b_stb, div_output_z_ack}), 32'd0);
    check("t_rst_done", 32'(done_count), 32'd0);
    check("t_rst_grant", 32'(grant_id), 32'd0);
    check("t_rst_data", resp_z | div_input_a | div_input_b, 32'd0);
    repeat (2) @(negedge aclk);
    #1 rstn = 1'b1;
    lat_min = 1; lat_max = 1;
    push(1, 32'h40C0_0000, 32'h4000_0000);
    drain(200, "t_rst_after_drain");
    check("t_rst_after_done", 32'(done_count), 32'd1);
    check("t_rst_after_grant", 32'(grant_id), 32'd1);

    // Random traffic on all ports
    lat_min = 1; lat_max = 4; partial = 1'b1; max_stall = 3;
    base = int'(done_count);
    for (int n = 0; n < 1000; n++) begin
      p = int'($urandom_range(N - 1, 0));
      k = 0;
      while (pa_q[p].size() >= 2 && k < 1000) begin @(negedge aclk); k++; end
      if ($urandom_range(15, 0) == 0) push(p, 32'h3F80_0000, 32'h0000_0000);
      else push(p, $urandom, $urandom);
      if ($urandom_range(3, 0) == 0) @(negedge aclk);
    end
    drain(60000, "t_rand_drain");
    check("t_rand_done", 32'(done_count), 32'(16'(base + 1000)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one FP32 divider (2..8).
REQ-002 SHALL have parameter DW, default 32, operand/result width.
REQ-003 SHALL have port aclk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_a, input, N_REQ*DW, dividend of requester i in bits [i*DW +: DW].
REQ-006 SHALL have port req_b, input, N_REQ*DW, divisor of requester i, same packing.
REQ-007 SHALL have port req_stb, input, N_REQ, requester i has a valid operand pair.
REQ-008 SHALL have port req_ack, output, N_REQ, one-cycle operand-accept pulse to requester i.
REQ-009 SHALL have port resp_z, output, DW, result bus shared by all requesters.
REQ-010 SHALL have port resp_stb, output, N_REQ, result valid for requester i.
REQ-011 SHALL have port resp_ack, input, N_REQ, requester i accepts result.
REQ-012 SHALL have ports div_input_a, output, DW; div_input_a_stb, output, 1; div_input_a_ack, input, 1, divider dividend channel.
REQ-013 SHALL have ports div_input_b, output, DW; div_input_b_stb, output, 1; div_input_b_ack, input, 1, divider divisor channel.
REQ-014 SHALL have ports div_output_z, input, DW; div_output_z_stb, input, 1; div_output_z_ack, output, 1, divider result channel.
REQ-015 SHALL have port busy, output, 1, high in any state except IDLE.
REQ-016 SHALL have port grant_id, output, clog2(N_REQ), index of current/last granted requester.
REQ-017 SHALL have port done_count, output, 16, count of completed divisions.

Function
REQ-018 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RETURN -> IDLE; one division in flight, no preemption.
REQ-019 IDLE: when any req_stb bit is set, SHALL grant the first set bit searching upward from (ptr+1) mod N_REQ, wrapping; ptr is the last served index.
REQ-020 On grant SHALL, in that same edge, latch req_a/req_b slices of the winner, set grant_id, pulse req_ack[winner] high for exactly one cycle, enter ISSUE.
REQ-021 Requester SHALL hold stb and operands until it sees req_ack; arbiter SHALL ignore a winner's stb in the cycle after its ack.
REQ-022 ISSUE: div_input_a_stb and div_input_b_stb SHALL be high with latched operands; transfer occurs on the first cycle with both stbs and both div acks high; next edge both stbs low, enter WAIT.
REQ-023 If only one div ack is high, SHALL keep both stbs asserted and wait (no partial transfer).
REQ-024 WAIT: div_output_z_ack SHALL be high; on div_output_z_stb && div_output_z_ack SHALL latch div_output_z, drop ack next edge, enter RETURN.
REQ-025 RETURN: resp_z SHALL carry the latched result and only resp_stb[grant_id] high; on resp_ack[grant_id] SHALL drop resp_stb, set ptr=grant_id, increment done_count (wraps 0xFFFF->0x0000), enter IDLE.
REQ-026 resp_ack of non-granted requesters SHALL be ignored; unbounded resp_ack stall SHALL hold RETURN with resp_z stable.
REQ-027 Requests arriving while busy SHALL remain pending; no request SHALL be lost or served twice.
REQ-028 Round-trip latency from req_ack pulse to resp_stb SHALL be 2 cycles plus divider latency; back-to-back grants SHALL have one IDLE cycle minimum.
REQ-029 div_input_*_stb SHALL be high only in ISSUE; div_output_z_ack only in WAIT; at most one req_ack/resp_stb bit high at any time.

Reset
REQ-030 rstn low SHALL asynchronously force IDLE, ptr=N_REQ-1, grant_id=0, all req_ack/resp_stb/div stbs/div_output_z_ack=0, resp_z=0, div_input_a/b=0, busy=0, done_count=0.
REQ-031 Reset mid-operation SHALL abandon the in-flight division with no response; divider shares rstn and restarts concurrently.
REQ-032 First request after reset deassertion SHALL be grantable on the first rising edge with rstn high.

Verification
REQ-033 Req 0: a=0x40C00000 (6.0), b=0x40000000 (2.0) -> resp_stb[0], resp_z=0x40400000, done_count=1.
REQ-034 All four req_stb high after reset -> grant order 0,1,2,3, each exactly one req_ack pulse, done_count=4.
REQ-035 Req 2: a=0x3F800000, b=0x00000000 -> resp_z=0x7F800000; req 1 raised meanwhile served next.
REQ-036 resp_ack[0] held low 10 cycles in RETURN -> resp_stb[0] and resp_z stable, no new grant, div stbs low.
REQ-037 rstn pulsed low during WAIT -> all outputs at reset values same cycle; new request completes correctly afterward.
REQ-038 Random 1000 requests on 4 ports vs reference model -> every result matches, no starvation (max wait <= 3 services).
